// File: rtl/div_seq_param_if.sv
// Operand/result handshake bundle for div_seq_param.
// master drives operands and out_ready; slave is the divider.
interface div_seq_param_if #(
  parameter int unsigned N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/div_seq_param.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define DIV_SIGNED_EN to honour is_signed (two's-complement division); otherwise unsigned only.
module div_seq_param #(
  parameter int unsigned N = 16
) (
  input logic            clk,
  input logic            rst,
  div_seq_param_if.slave bus
);
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [N-1:0]    quotient_q, quotient_d, remainder_q, remainder_d;
  logic            dbz_q, dbz_d;
  logic [N-1:0]    dvd_mag, dvs_mag, fix_quo, fix_rem;
  logic [N:0]      trial;

`ifdef DIV_SIGNED_EN
  logic dvd_neg, dvs_neg;
  logic neg_quo_q, neg_rem_q;

  assign dvd_neg = bus.is_signed & bus.dividend[N-1];
  assign dvs_neg = bus.is_signed & bus.divisor[N-1];
  // |-2^(N-1)| still fits in N unsigned bits
  assign dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
  assign dvs_mag = dvs_neg ? -bus.divisor : bus.divisor;
  assign fix_quo = neg_quo_q ? -quo_q : quo_q;
  assign fix_rem = neg_rem_q ? -rem_q : rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (state_q == StIdle && bus.in_valid) begin
      neg_quo_q <= dvd_neg ^ dvs_neg;
      neg_rem_q <= dvd_neg;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = bus.is_signed;
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
  assign fix_quo = quo_q;
  assign fix_rem = rem_q;
`endif

  // Trial subtraction of the shifted partial remainder; trial[N] is the borrow.
  assign trial = {rem_q, quo_q[N-1]} - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.divisor == '0) begin
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
            state_d     = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = dvd_mag;
            dvs_d   = dvs_mag;
            cnt_d   = CntW'(N);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = trial[N] ? {rem_q[N-2:0], quo_q[N-1]} : trial[N-1:0];
        quo_d = {quo_q[N-2:0], ~trial[N]};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        quotient_d  = fix_quo;
        remainder_d = fix_rem;
        dbz_d       = 1'b0;
        state_d     = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_seq_param.sv
// Self-checking bench for div_seq_param (N=8): vector table, backpressure and mid-op reset.
// Expected results follow the DIV_SIGNED_EN build setting.
module tb_div_seq_param;
  localparam int unsigned N = 8;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] qs;
    logic [7:0] rs;
    logic [7:0] qu;
    logic [7:0] ru;
  } vec_t;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  res_t sb[$];
  vec_t vecs[11];

  div_seq_param_if #(.N(N)) bus ();

  div_seq_param #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic res_t expect_of(input vec_t v);
    res_t e;
    e.dbz = (v.b == 8'h00);
`ifdef DIV_SIGNED_EN
    e.q = v.qs;
    e.r = v.rs;
`else
    e.q = v.qu;
    e.r = v.ru;
`endif
    return e;
  endfunction

  task automatic drive_accept(input vec_t v, input bit push);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.dividend  = v.a;
    bus.divisor   = v.b;
    bus.is_signed = v.s;
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    if (push) sb.push_back(expect_of(v));
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges from (and including) the accepting edge until out_valid.
  task automatic wait_out(input int lat);
    int edges = 1;
    while (!bus.out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
    end
    check("latency", 32'(edges), 32'(lat));
  endtask

  task automatic pop_cmp();
    res_t e;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("quotient", 32'(bus.quotient), 32'(e.q));
      check("remainder", 32'(bus.remainder), 32'(e.r));
      check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
    check("out_valid_after_handshake", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    drive_accept(v, 1'b1);
    wait_out((v.b == 8'h00) ? 1 : int'(N) + 2);
    pop_cmp();
    handshake();
  endtask

  initial begin
    int   stale;
    vec_t v;
    //         a      b      s     qs     rs     qu     ru
    vecs[0]  = '{8'd200, 8'd7, 1'b0, 8'h1C, 8'h04, 8'h1C, 8'h04};
    vecs[1]  = '{8'h37, 8'h00, 1'b0, 8'hFF, 8'h37, 8'hFF, 8'h37};
    vecs[2]  = '{8'h37, 8'h00, 1'b1, 8'hFF, 8'h37, 8'hFF, 8'h37};
    vecs[3]  = '{8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 8'h7C, 8'h01};
    vecs[4]  = '{8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 8'h00, 8'h07};
    vecs[5]  = '{8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 8'h00, 8'h80};
    vecs[6]  = '{8'd100, 8'd10, 1'b0, 8'h0A, 8'h00, 8'h0A, 8'h00};
    vecs[7]  = '{8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[8]  = '{8'h81, 8'h03, 1'b1, 8'hD6, 8'hFF, 8'h2B, 8'h00};
    vecs[9]  = '{8'h05, 8'h09, 1'b0, 8'h00, 8'h05, 8'h00, 8'h05};
    vecs[10] = '{8'h80, 8'h01, 1'b1, 8'h80, 8'h00, 8'h80, 8'h00};

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_quotient", 32'(bus.quotient), 32'd0);
    check("reset_remainder", 32'(bus.remainder), 32'd0);
    check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Backpressure: result must hold and new operands must be refused.
    bus.out_ready = 1'b0;
    drive_accept(vecs[0], 1'b1);
    wait_out(int'(N) + 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = 8'd9;
      bus.divisor  = 8'd3;
      @(posedge clk);
      #1;
      check("bp_quotient", 32'(bus.quotient), 32'h1C);
      check("bp_remainder", 32'(bus.remainder), 32'h04);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    pop_cmp();
    handshake();

    // Reset during the 4th CALC cycle aborts the operation.
    drive_accept(vecs[0], 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_quotient", 32'(bus.quotient), 32'd0);
    check("midrst_remainder", 32'(bus.remainder), 32'd0);
    check("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    check("no_stale_out_valid", 32'(stale), 32'd0);
    v = vecs[6];
    run_vec(v);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_seq_param.md
# div_seq_param

Parametrised sequential restoring divider with valid/ready handshakes on both sides. It computes one quotient bit per cycle. It adds divide-by-zero detection, result backpressure and optional two's-complement signed division. It sits between the datapath's operand registers and the result write-back stage, and serves all integer divide/remainder operations.

## Interface
- N, default 16: operand and result width in bits, N >= 2.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands; equals (state == IDLE).
- dividend  input  N  dividend, captured on the input handshake.
- divisor  input  N  divisor, captured on the input handshake.
- is_signed  input  1  1 = signed operation; captured on the input handshake.
- out_valid  output  1  quotient, remainder and div_by_zero are valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  N  quotient.
- remainder  output  N  remainder.
- div_by_zero  output  1  set when the captured divisor was 0.
- busy  output  1  state != IDLE.

## Operation
- States and transitions:
  - IDLE: on in_valid & in_ready, capture the operands and mode.
    - If divisor == 0, go to DONE.
    - Otherwise go to CALC, with the iteration counter set to N.
  - CALC: one restoring step per cycle.
    - Step: shift {rem, quo} left by 1; if rem_upper >= divisor magnitude, subtract it and set the quotient LSB.
    - After N steps, go to FIX.
  - FIX: apply the sign correction, register quotient and remainder, go to DONE.
  - DONE: out_valid = 1. On out_valid & out_ready, go to IDLE.
- Arithmetic:
  - The iteration datapath is 2N bits wide and operates on N-bit unsigned magnitudes.
  - In signed mode, |-2^(N-1)| = 2^(N-1) fits in N unsigned bits, so no extra width is needed.
- Signed results:
  - Quotient is negated when the operand signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Overflow case -2^(N-1) / -1 gives quotient = -2^(N-1), remainder = 0. This result falls out naturally; no special case is required.
- Divide by zero:
  - quotient = all ones, remainder = dividend unmodified (both modes), div_by_zero = 1.
  - Otherwise div_by_zero = 0.
- Result registers:
  - quotient, remainder and div_by_zero hold stable while out_valid & !out_ready.
  - After the output handshake they keep their last values until the next result overwrites them.
  - in_valid is ignored in every state except IDLE.

## Timing
- Reset (asynchronous):
  - state = IDLE.
  - quotient = 0, remainder = 0, div_by_zero = 0, out_valid = 0, busy = 0.
  - in_ready = 1, because it decodes IDLE.
- Normal latency: out_valid rises N+2 clock edges after the accepting edge (N CALC edges plus 1 FIX edge, counted from entry into CALC).
- Divide-by-zero latency: out_valid rises 1 edge after the accepting edge.
- Throughput:
  - The output handshake edge returns the block to IDLE; in_ready is 1 in the following cycle.
  - Minimum spacing between input handshakes is N+3 cycles for a normal divide and 2 cycles for divide-by-zero.
- Reset asserted in any state aborts the operation immediately:
  - No out_valid is produced for the aborted operation.
  - All outputs take their reset values.

## Configuration
- DIV_SIGNED_EN defined:
  - is_signed is honoured.
  - Operand magnitudes are taken at capture; FIX applies the sign correction.
- DIV_SIGNED_EN undefined:
  - is_signed is ignored and every operation is unsigned.
  - The negation logic is removed.
  - FIX remains a 1-cycle pass-through, so latency is identical in both builds.

## Test plan
All scenarios use N=8 and a build with DIV_SIGNED_EN defined.
- Unsigned 200 / 7 (is_signed=0):
  - quotient = 28 (0x1C), remainder = 4.
  - out_valid exactly 10 edges after acceptance; div_by_zero = 0.
- Divide by zero 0x37 / 0, both modes:
  - quotient = 0xFF, remainder = 0x37, div_by_zero = 1.
  - out_valid 1 edge after acceptance.
- Signed -7 / 2 (0xF9 / 0x02):
  - quotient = 0xFD (-3), remainder = 0xFF (-1).
  - Also 7 / -2: quotient = 0xFD, remainder = 0x01.
- Signed overflow -128 / -1 (0x80 / 0xFF):
  - quotient = 0x80, remainder = 0x00, div_by_zero = 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid.
  - Outputs stay stable and in_ready stays 0.
  - in_valid pulses during this window are not accepted.
  - After the out_ready handshake, in_ready = 1 in the next cycle.
- Reset mid-operation: assert rst at the 4th CALC cycle.
  - All outputs take their reset values immediately.
  - No stale out_valid appears.
  - A following 100 / 10 returns quotient = 10, remainder = 0.
